// File: rtl/check_node_minsum.sv
// Offset min-sum LDPC check-node processor.
// Collects DEG signed variable-to-check messages serially, tracking the two
// smallest magnitudes, the position of the smallest, and the sign parity.
// Then emits DEG check-to-variable messages serially, each being the
// offset-corrected min-sum of all other inputs of the row.
//
// Handshake: an input is consumed on a rising edge only when i_val=1 and
// o_rdy=1 (o_rdy is high throughout the collect phase); i_val while o_rdy=0
// is ignored. Output has no backpressure: o_val is high for exactly DEG
// consecutive cycles per frame and the consumer must take every one.
module check_node_minsum #(
    parameter int W    = 16,
    parameter int DEG  = 6,
    parameter int IDXW = 3,
    parameter int OFS  = 0
) (
    input  logic         clk,
    input  logic         xrst,
    input  logic [W-1:0] i_data,
    input  logic         i_val,
    output logic         o_rdy,
    output logic [W-1:0] o_data,
    output logic         o_val,
    output logic [2:0]   o_init,
    output logic         dbg_state
);

    typedef enum logic {S_COLL = 1'b0, S_EMIT = 1'b1} state_t;

    localparam logic [W-1:0]    MAX_MAG = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]    MIN_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]    OFS_W   = W'(OFS);
    localparam logic [IDXW-1:0] K_LAST  = IDXW'(DEG - 1);

    state_t          state;
    logic [IDXW-1:0] k;
    logic [IDXW-1:0] idx;
    logic [W-1:0]    min1;
    logic [W-1:0]    min2;
    logic            sacc;
    logic [DEG-1:0]  sgn;

    logic            in_sgn;
    logic [W-1:0]    in_neg;
    logic [W-1:0]    in_mag;
    logic [W-1:0]    sel_mag;
    logic [W-1:0]    ofs_mag;
    logic            out_sgn;
    logic [W-1:0]    emit_data;

    assign o_rdy     = (state == S_COLL);
    assign dbg_state = state;

    // Input magnitude, with the most negative value saturated to the largest
    // positive magnitude so it stays representable in W-1 bits.
    always_comb begin
        in_sgn = i_data[W-1];
        in_neg = -i_data;
        in_mag = i_data;
        if (in_sgn) begin
            in_mag = (i_data == MIN_NEG) ? MAX_MAG : in_neg;
        end
    end

    // Output value for position k: exclude own magnitude via idx, apply the
    // offset with a floor at zero, and never produce a negated zero.
    always_comb begin
        sel_mag   = (k == idx) ? min2 : min1;
        ofs_mag   = (sel_mag > OFS_W) ? (sel_mag - OFS_W) : '0;
        out_sgn   = sacc ^ sgn[k];
        emit_data = ofs_mag;
        if (out_sgn && (ofs_mag != '0)) begin
            emit_data = -ofs_mag;
        end
    end

    // Frame FSM: collect DEG inputs, then emit DEG registered outputs.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state  <= S_COLL;
            k      <= '0;
            idx    <= '0;
            min1   <= '0;
            min2   <= '0;
            sacc   <= 1'b0;
            sgn    <= '0;
            o_data <= '0;
            o_val  <= 1'b0;
            o_init <= 3'd0;
        end else begin
            case (state)
                S_COLL: begin
                    o_val  <= 1'b0;
                    o_init <= 3'd0;
                    if (i_val) begin
                        sgn[k] <= in_sgn;
                        if (k == '0) begin
                            min1 <= in_mag;
                            min2 <= MAX_MAG;
                            idx  <= '0;
                            sacc <= in_sgn;
                        end else begin
                            sacc <= sacc ^ in_sgn;
                            // Strict compares: on a tie the earlier index keeps min1.
                            if (in_mag < min1) begin
                                min2 <= min1;
                                min1 <= in_mag;
                                idx  <= k;
                            end else if (in_mag < min2) begin
                                min2 <= in_mag;
                            end
                        end
                        if (k == K_LAST) begin
                            k     <= '0;
                            state <= S_EMIT;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                S_EMIT: begin
                    o_data <= emit_data;
                    o_val  <= 1'b1;
                    o_init <= (k == '0) ? 3'd1 : 3'd0;
                    if (k == K_LAST) begin
                        k     <= '0;
                        state <= S_COLL;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: begin
                    state <= S_COLL;
                    k     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_check_node_minsum.sv
// Bench for check_node_minsum: two instances (OFS=0 and OFS=1) share the
// same stimulus. Expected outputs are derived per frame from a direct
// "min over all other inputs / xor of all other signs" reference.
module tb_check_node_minsum;

    localparam int W    = 16;
    localparam int DEG  = 6;
    localparam int IDXW = 3;

    // Clock / reset
    logic clk = 1'b0;
    logic xrst;
    always #5 clk = ~clk;

    logic [W-1:0] i_data;
    logic         i_val;

    logic         o_rdy0, o_val0, dbg0;
    logic [W-1:0] o_data0;
    logic [2:0]   o_init0;
    logic         o_rdy1, o_val1, dbg1;
    logic [W-1:0] o_data1;
    logic [2:0]   o_init1;

    check_node_minsum #(.W(W), .DEG(DEG), .IDXW(IDXW), .OFS(0)) u_dut0 (
        .clk(clk), .xrst(xrst), .i_data(i_data), .i_val(i_val),
        .o_rdy(o_rdy0), .o_data(o_data0), .o_val(o_val0), .o_init(o_init0),
        .dbg_state(dbg0)
    );

    check_node_minsum #(.W(W), .DEG(DEG), .IDXW(IDXW), .OFS(1)) u_dut1 (
        .clk(clk), .xrst(xrst), .i_data(i_data), .i_val(i_val),
        .o_rdy(o_rdy1), .o_data(o_data1), .o_val(o_val1), .o_init(o_init1),
        .dbg_state(dbg1)
    );

    // Scoreboard state
    logic [W+2:0] exp_q0[$];
    logic [W+2:0] exp_q1[$];
    int           total = 0;
    int           bad   = 0;
    logic         mon_en = 1'b0;
    logic [W-1:0] last0, last1;
    logic [W+2:0] e0, e1;
    logic [W-1:0] fr [DEG];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
        end
    endtask

    function automatic int tb_mag(input logic [W-1:0] v);
        int x;
        x = int'($signed(v));
        if (x < 0) x = -x;
        if (x > 32767) x = 32767;
        return x;
    endfunction

    // Reference: for each output position, min magnitude and sign parity of
    // every other input.
    task automatic push_exp();
        int  m, mo, val;
        bit  s;
        logic [W-1:0] d;
        for (int j = 0; j < DEG; j++) begin
            m = 32767;
            s = 1'b0;
            for (int i = 0; i < DEG; i++) begin
                if (i != j) begin
                    if (tb_mag(fr[i]) < m) m = tb_mag(fr[i]);
                    s = s ^ fr[i][W-1];
                end
            end
            for (int ofs = 0; ofs < 2; ofs++) begin
                mo  = (m > ofs) ? m - ofs : 0;
                val = s ? -mo : mo;
                d   = W'(val);
                if (ofs == 0) exp_q0.push_back({(j == 0) ? 3'd1 : 3'd0, d});
                else          exp_q1.push_back({(j == 0) ? 3'd1 : 3'd0, d});
            end
        end
    endtask

    task automatic set_frame(input int a, input int b, input int c,
                             input int d, input int e, input int f);
        fr[0] = W'(a); fr[1] = W'(b); fr[2] = W'(c);
        fr[3] = W'(d); fr[4] = W'(e); fr[5] = W'(f);
    endtask

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(0, 4))
            0:       return W'(int'($urandom_range(0, 6)) - 3);
            1:       return 16'h8000;
            2:       return 16'h7fff;
            default: return W'($urandom);
        endcase
    endfunction

    // Driver: called and returns aligned on a negedge. Sends fr[] with up to
    // gap_max idle cycles between inputs, then optionally drives junk i_val
    // pulses while o_rdy is low and checks the o_rdy-low window length.
    task automatic send_frame(input int gap_max, input bit junk);
        int n;
        n = 0;
        while (!o_rdy0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rdy_wait", o_rdy0, 1'b1);
        push_exp();
        for (int i = 0; i < DEG; i++) begin
            repeat ($urandom_range(0, gap_max)) begin
                i_val  = 1'b0;
                i_data = W'($urandom);
                @(negedge clk);
            end
            i_val  = 1'b1;
            i_data = fr[i];
            @(negedge clk);
        end
        n = 0;
        while (!o_rdy0 && n < 50) begin
            i_val  = junk ? 1'($urandom_range(0, 1)) : 1'b0;
            i_data = junk ? W'($urandom) : '0;
            n++;
            @(negedge clk);
        end
        i_val = 1'b0;
        check("rdy_low_cycles", n, DEG);
    endtask

    // Monitor: pop and compare on every o_val cycle; outside those cycles
    // o_init must be 0 and o_data must hold.
    always @(negedge clk) begin
        if (!xrst) begin
            last0 = '0;
            last1 = '0;
        end else if (mon_en) begin
            if (o_val0) begin
                if (exp_q0.size() == 0) check("spurious_val0", o_val0, 1'b0);
                else begin
                    e0 = exp_q0.pop_front();
                    check("out0", {o_init0, o_data0}, e0);
                end
                last0 = o_data0;
            end else begin
                check("idle0", {o_init0, o_data0}, {3'd0, last0});
            end
            if (o_val1) begin
                if (exp_q1.size() == 0) check("spurious_val1", o_val1, 1'b0);
                else begin
                    e1 = exp_q1.pop_front();
                    check("out1", {o_init1, o_data1}, e1);
                end
                last1 = o_data1;
            end else begin
                check("idle1", {o_init1, o_data1}, {3'd0, last1});
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        xrst   = 1'b0;
        i_val  = 1'b0;
        i_data = '0;
        repeat (2) @(negedge clk);
        check("rst_data0", o_data0, 0);
        check("rst_val0", o_val0, 0);
        check("rst_init0", o_init0, 0);
        check("rst_rdy0", o_rdy0, 1);
        check("rst_state0", dbg0, 0);
        check("rst_rdy1", o_rdy1, 1);
        xrst   = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        // Basic, tie, saturation (OFS=1 instance covers the offset cases)
        set_frame(5, -3, 7, 2, -9, 4);          send_frame(0, 1'b0);
        set_frame(4, -4, 4, 4, 4, 4);           send_frame(0, 1'b0);
        set_frame(-32768, 100, 100, 100, 100, 100); send_frame(0, 1'b0);
        set_frame(0, 0, -5, 3, -1, 2);          send_frame(0, 1'b0);

        // Gaps between inputs, junk i_val during emit, then a clean frame
        set_frame(5, -3, 7, 2, -9, 4);          send_frame(3, 1'b1);
        set_frame(1, 1, 1, 1, 1, 1);            send_frame(0, 1'b1);

        // Asynchronous reset after 3 accepted inputs
        set_frame(5, -3, 7, 2, -9, 4);
        for (int i = 0; i < 3; i++) begin
            i_val  = 1'b1;
            i_data = fr[i];
            @(negedge clk);
        end
        i_val = 1'b0;
        @(posedge clk);
        #3 xrst = 1'b0;
        #1;
        check("arst_data0", o_data0, 0);
        check("arst_data1", o_data1, 0);
        check("arst_val0", o_val0, 0);
        check("arst_init0", o_init0, 0);
        check("arst_rdy0", o_rdy0, 1);
        check("arst_state0", dbg0, 0);
        @(negedge clk);
        @(posedge clk);
        #3 xrst = 1'b1;
        @(negedge clk);
        check("rel_rdy0", o_rdy0, 1);
        send_frame(0, 1'b0);

        // Random frames
        for (int f = 0; f < 30; f++) begin
            for (int i = 0; i < DEG; i++) fr[i] = rnd_val();
            send_frame($urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        n = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("drain", exp_q0.size() + exp_q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/check_node_minsum.md
Name: check_node_minsum

Overview:
- Min-sum check-node processor for the LDPC decoder; it sits directly upstream of the variable-node accumulator ("add").
- It collects the DEG signed variable-to-check messages of one check row, serially.
- It then emits DEG check-to-variable messages, serially. Each output is the offset-corrected min-sum of all other inputs.
- o_data/o_val/o_init connect directly to the accumulator's i_data/i_val/i_init.

Parameters:
- W, 16, message width (signed two's complement).
- DEG, 6, check-node degree: messages per frame, in and out; must be at least 2.
- IDXW, 3, width of the index/counter; must satisfy 2^IDXW >= DEG.
- OFS, 0, offset subtracted from the output magnitude (offset min-sum); range 0..2^(W-1)-1.

Ports:
- clk  in  1  clock; rising edge.
- xrst  in  1  reset; asynchronous, active-low.
- i_data  in  W  signed input message.
- i_val  in  1  input valid; sampled only while o_rdy=1.
- o_rdy  out  1  block can accept input (collect phase).
- o_data  out  W  signed output message.
- o_val  out  1  output valid; high for exactly DEG cycles per frame.
- o_init  out  3  3'd1 on the first output of a frame, 3'd0 otherwise.

Behaviour:
- Reset (xrst low, asynchronous): state=S_COLL, k=0, o_data=0, o_val=0, o_init=0, o_rdy=1. All min/sign/index registers are cleared. A reset mid-frame discards the partial frame.
- o_rdy = (state==S_COLL), decoded combinationally from the state register.
- Magnitude of input x: |x|, saturated so that -2^(W-1) maps to 2^(W-1)-1. Zero counts as positive (sign bit 0).
- S_COLL, on each edge with i_val=1:
  - Store the sign of x in sgn[k]; sacc ^= sign.
  - If k==0: min1=mag, min2=2^(W-1)-1, idx=0, sacc=sign.
  - Else if mag<min1: min2=min1, min1=mag, idx=k.
  - Else if mag<min2: min2=mag.
  - Comparisons are strict, so on a tie the earliest index keeps min1.
  - k increments. When k==DEG-1 is accepted, set k=0 and move to S_EMIT.
- i_val=0 in S_COLL: nothing changes; gaps between inputs are allowed.
- S_EMIT, one output per edge, k=0..DEG-1:
  - m = (k==idx) ? min2 : min1.
  - m' = (m>OFS) ? m-OFS : 0.
  - s = sacc ^ sgn[k].
  - o_data = s ? -m' : m'. When m'=0 the output is 0; a negated zero is not allowed.
  - o_val=1. o_init=1 only when k==0.
  - At k==DEG-1: return to S_COLL and set k=0.
- Outside emitted cycles: o_val=0 and o_init=0; o_data holds its last value.
- Timing: the last input is sampled at edge E0. Outputs are registered at edges E1..E_DEG. o_rdy is low from after E0 until after E_DEG.
  - A new frame's first input is accepted at E_DEG+1 at the earliest.
  - Throughput: one frame every 2*DEG cycles when inputs arrive back-to-back.
- i_val while o_rdy=0: ignored completely; it is not counted and not stored.
- No output backpressure. The consumer must accept every o_val cycle.

Test Plan (DEG=6, W=16 unless stated):
1. OFS=0; inputs 5,-3,7,2,-9,4 back-to-back.
   - Required: min1=2, idx=3, min2=3, sacc=0.
   - o_data = 2,-2,2,3,-2,2 on 6 consecutive cycles.
   - o_init = 1,0,0,0,0,0; o_val then drops.
2. Tie: inputs 4,-4,4,4,4,4.
   - Required: idx=0, min2=4, sacc=1.
   - Outputs -4,4,-4,-4,-4,-4.
3. Saturation: inputs -32768,100,100,100,100,100.
   - Required: min1=100, idx=1, min2=100, sacc=1.
   - Outputs 100,-100,-100,-100,-100,-100.
4. OFS=1 instance, stimulus as in test 1 -> outputs 1,-1,1,2,-1,1.
5. Stimulus as in test 1, plus idle cycles between inputs and i_val pulses (value 0) during S_EMIT.
   - Required: outputs identical to test 1.
   - Required: the next frame starts clean; a following frame of all 1 gives 1,1,1,1,1,1.
6. Assert xrst asynchronously (mid-cycle) after 3 accepted inputs.
   - Required: all outputs zero immediately; o_rdy=1 after release.
   - Then stimulus as in test 1 -> exact test 1 output, with no residue from the partial frame.
